// File: rtl/bus_pkg.sv
// Shared definitions for the packet bus endpoint: address width, broadcast ID
// and destination-field extraction.
package bus_pkg;

    localparam int unsigned ID_W         = 8;
    localparam logic [7:0]  BROD_DEFAULT = 8'hFF;
    localparam int unsigned PKT_MAX_W    = 64;

    // Destination ID is the top ID_W bits of a pckg-wide packet (zero-extended to PKT_MAX_W).
    function automatic logic [ID_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned           pckg);
        return ID_W'(pkt >> (pckg - ID_W));
    endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy counter; head reads as 0 when empty.
module bus_sync_fifo #(
    parameter int unsigned PCKG  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [PCKG-1:0]          wr_data,
    input  logic                     rd_en,
    output logic [PCKG-1:0]          rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PCKG-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_wr;
    logic            w_rd;

    // Full/empty come from registered occupancy, so a same-cycle read never frees a slot.
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bus_endpoint.sv
// Bus drop endpoint: TX FIFO toward the arbiter's pending/pop port, and an
// address-filtered RX FIFO with a saturating overflow drop counter.
module bus_endpoint
    import bus_pkg::*;
#(
    parameter int unsigned     PCKG  = 16,
    parameter int unsigned     DEPTH = 4,
    parameter logic [ID_W-1:0] ID    = 8'h00,
    parameter logic [ID_W-1:0] BROD  = BROD_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_valid,
    input  logic [PCKG-1:0] tx_data,
    output logic            tx_ready,
    output logic            pndng,
    output logic [PCKG-1:0] D_pop,
    input  logic            pop,
    input  logic            push,
    input  logic [PCKG-1:0] D_push,
    output logic            rx_valid,
    output logic [PCKG-1:0] rx_data,
    input  logic            rx_ready,
    output logic [7:0]      drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            w_tx_full;
    logic            w_tx_empty;
    logic [CW-1:0]   w_tx_count;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic [CW-1:0]   w_rx_count;
    logic [ID_W-1:0] w_dest;
    logic            w_match_push;
    logic            w_drop;
    logic [7:0]      r_drop_cnt;

    assign tx_ready = (w_tx_count != CW'(DEPTH));
    assign pndng    = (w_tx_count != '0);
    assign rx_valid = (w_rx_count != '0);
    assign drop_cnt = r_drop_cnt;

    bus_sync_fifo #(.PCKG(PCKG), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_valid && !w_tx_full),
        .wr_data (tx_data),
        .rd_en   (pop && !w_tx_empty),
        .rd_data (D_pop),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .count   (w_tx_count)
    );

    // Accept packets addressed to this drop or broadcast; others are invisible.
    assign w_dest       = pkt_dest(PKT_MAX_W'(D_push), PCKG);
    assign w_match_push = push && ((w_dest == ID) || (w_dest == BROD));
    assign w_drop       = w_match_push && w_rx_full;

    bus_sync_fifo #(.PCKG(PCKG), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_match_push && !w_rx_full),
        .wr_data (D_push),
        .rd_en   (rx_ready && !w_rx_empty),
        .rd_data (rx_data),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .count   (w_rx_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bus_endpoint.sv
// Randomized + directed bench for bus_endpoint with a queue-based reference model.
module tb_bus_endpoint;

    localparam int unsigned PCKG  = 16;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  ID    = 8'h03;
    localparam logic [7:0]  BROD  = 8'hFF;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tx_valid = 1'b0;
    logic [PCKG-1:0] tx_data = '0;
    logic            tx_ready;
    logic            pndng;
    logic [PCKG-1:0] D_pop;
    logic            pop = 1'b0;
    logic            push = 1'b0;
    logic [PCKG-1:0] D_push = '0;
    logic            rx_valid;
    logic [PCKG-1:0] rx_data;
    logic            rx_ready = 1'b0;
    logic [7:0]      drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: plain packet queues plus a saturating drop tally.
    logic [PCKG-1:0] exp_tx[$];
    logic [PCKG-1:0] exp_rx[$];
    int              exp_drop = 0;
    bit              started  = 1'b0;

    bus_endpoint #(.PCKG(PCKG), .DEPTH(DEPTH), .ID(ID), .BROD(BROD)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Predictor: apply each edge's inputs to the model using pre-edge occupancy.
    always @(posedge clk) begin
        int  txn;
        int  rxn;
        bit  matched;
        if (!reset) begin
            exp_tx.delete();
            exp_rx.delete();
            exp_drop = 0;
            started  = 1'b1;
        end else begin
            txn = exp_tx.size();
            rxn = exp_rx.size();
            if (pop && txn != 0) void'(exp_tx.pop_front());
            if (tx_valid && txn != DEPTH) exp_tx.push_back(tx_data);
            matched = push && (D_push[15:8] == ID || D_push[15:8] == BROD);
            if (rx_ready && rxn != 0) void'(exp_rx.pop_front());
            if (matched) begin
                if (rxn == DEPTH) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    exp_rx.push_back(D_push);
                end
            end
        end
    end

    // Monitor: compare every presented output against the model, away from the edge.
    always @(negedge clk) begin
        logic [PCKG-1:0] tx_head;
        logic [PCKG-1:0] rx_head;
        if (started) begin
            tx_head = (exp_tx.size() != 0) ? exp_tx[0] : '0;
            rx_head = (exp_rx.size() != 0) ? exp_rx[0] : '0;
            chk("mon_tx_ready", 32'(tx_ready), 32'(exp_tx.size() != DEPTH));
            chk("mon_pndng",    32'(pndng),    32'(exp_tx.size() != 0));
            chk("mon_D_pop",    32'(D_pop),    32'(tx_head));
            chk("mon_rx_valid", 32'(rx_valid), 32'(exp_rx.size() != 0));
            chk("mon_rx_data",  32'(rx_data),  32'(rx_head));
            chk("mon_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        end
    end

    task automatic step(input logic rst, input logic tv, input logic [15:0] td,
                        input logic pp, input logic ps, input logic [15:0] dp,
                        input logic rr);
        reset    = rst;
        tx_valid = tv;
        tx_data  = td;
        pop      = pp;
        push     = ps;
        D_push   = dp;
        rx_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    function automatic logic [15:0] rand_pkt();
        logic [7:0] d;
        case ($urandom_range(0, 2))
            0:       d = ID;
            1:       d = BROD;
            default: d = 8'($urandom_range(0, 255));
        endcase
        return {d, 8'($urandom_range(0, 255))};
    endfunction

    initial begin
        logic [15:0] v;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_pndng",    32'(pndng),    32'd0);
        chk("rst_D_pop",    32'(D_pop),    32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'd0);
        chk("rst_drop",     32'(drop_cnt), 32'd0);
        idle();

        // TX order and full
        for (int i = 1; i <= 4; i++) begin
            v = {8'(i), 8'(i)};
            step(1'b1, 1'b1, v, 1'b0, 1'b0, 16'h0, 1'b0);
        end
        chk("tx_full_ready", 32'(tx_ready), 32'd0);
        step(1'b1, 1'b1, 16'h0505, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            v = {8'(i), 8'(i)};
            chk("tx_order", 32'(D_pop), 32'(v));
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        chk("tx_empty_pndng", 32'(pndng), 32'd0);
        chk("tx_empty_dpop",  32'(D_pop), 32'd0);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("tx_extra_pop",   32'(pndng), 32'd0);
        step(1'b1, 1'b1, 16'h0707, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("tx_after_extra", 32'(D_pop), 32'h0707);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

        // RX filter
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h05BB, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFCC, 1'b0);
        chk("rx_filter_head", 32'(rx_data),  32'h03AA);
        chk("rx_filter_drop", 32'(drop_cnt), 32'd0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rx_filter_2nd",  32'(rx_data),  32'hFFCC);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rx_filter_empty", 32'(rx_valid), 32'd0);

        // RX overflow and saturation
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, {8'h03, 8'(i)}, 1'b0);
        chk("rx_ovf_drop", 32'(drop_cnt), 32'd2);
        chk("rx_ovf_head", 32'(rx_data),  32'h0300);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, {8'hFF, 8'(i)}, 1'b0);
        chk("rx_sat_drop", 32'(drop_cnt), 32'hFF);

        // RX full with simultaneous read still drops
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, {8'h03, 8'(i)}, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0311, 1'b1);
        chk("rx_full_rd_drop", 32'(drop_cnt), 32'd1);
        chk("rx_full_rd_head", 32'(rx_data),  32'h0302);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rx_full_rd_occ3", 32'(rx_valid), 32'd0);

        // TX half-full simultaneous write and pop
        step(1'b1, 1'b1, 16'h00A1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h00A2, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h00A3, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("tx_simul_head", 32'(D_pop), 32'h00A2);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("tx_simul_next", 32'(D_pop), 32'h00A3);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("tx_simul_empty", 32'(pndng), 32'd0);

        // Reset mid-operation
        step(1'b1, 1'b1, 16'h00B1, 1'b0, 1'b1, 16'h0301, 1'b0);
        step(1'b1, 1'b1, 16'h00B2, 1'b0, 1'b1, 16'h0302, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0303, 1'b0);
        step(1'b0, 1'b1, 16'h00B3, 1'b1, 1'b1, 16'h0399, 1'b1);
        chk("midrst_pndng",    32'(pndng),    32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_drop",     32'(drop_cnt), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pkt(),
                 1'($urandom_range(0, 2) == 0));
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
